// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead slice per stage, carry registered between stages.
// Latency: STAGES = WIDTH/BLOCK cycles from accept to out_valid; one operation per cycle.
// Backpressure: a single global enable stalls every stage while a presented result is not taken; in_ready = enable.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / BLOCK;
    localparam int LAST   = STAGES - 1;

    if ((WIDTH % BLOCK) != 0 || BLOCK < 2 || BLOCK > 16) begin : g_bad_param
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK and BLOCK must be 2..16");
    end

    // Returns {carry out of slice, carry into slice MSB, slice sum}; every carry is a flat
    // generate/propagate expression of the slice carry-in rather than a ripple chain.
    function automatic logic [BLOCK+1:0] cla_slice(input logic [BLOCK-1:0] x,
                                                   input logic [BLOCK-1:0] y,
                                                   input logic             cin);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        g = x & y;
        p = x ^ y;
        for (int i = 0; i <= BLOCK; i++) begin
            term = cin;
            for (int m = 0; m < i; m++) term = term & p[m];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return {c[BLOCK], c[BLOCK-1], p ^ c[BLOCK-1:0]};
    endfunction

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] nxt_a [STAGES];
    logic [WIDTH-1:0] nxt_b [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];
    logic             nxt_v [STAGES];
    logic             nxt_ovf;

    logic [WIDTH-1:0] stg_a;
    logic [WIDTH-1:0] stg_b;
    logic [WIDTH-1:0] stg_s;
    logic             stg_c;
    logic [BLOCK+1:0] stg_r;
    logic             en;

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = (sum == {WIDTH{1'b0}});
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    // Stage k consumes the operands/partial sum held by stage k-1 (stage 0 takes the ports)
    // and fills in slice k; upper operand slices and lower sum slices travel along untouched.
    always_comb begin
        nxt_ovf = 1'b0;
        stg_a   = a;
        stg_b   = b;
        stg_s   = {WIDTH{1'b0}};
        stg_c   = 1'b0;
        stg_r   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                stg_a    = a;
                stg_b    = sub ? ~b : b;
                stg_s    = {WIDTH{1'b0}};
                stg_c    = sub;
                nxt_v[k] = in_valid;
            end else begin
                stg_a    = a_q[(k == 0) ? 0 : k - 1];
                stg_b    = b_q[(k == 0) ? 0 : k - 1];
                stg_s    = s_q[(k == 0) ? 0 : k - 1];
                stg_c    = c_q[(k == 0) ? 0 : k - 1];
                nxt_v[k] = v_q[(k == 0) ? 0 : k - 1];
            end
            stg_r = cla_slice(stg_a[k*BLOCK +: BLOCK], stg_b[k*BLOCK +: BLOCK], stg_c);
            nxt_a[k] = stg_a;
            nxt_b[k] = stg_b;
            nxt_s[k] = stg_s;
            nxt_s[k][k*BLOCK +: BLOCK] = stg_r[BLOCK-1:0];
            nxt_c[k] = stg_r[BLOCK+1];
            if (k == LAST) nxt_ovf = stg_r[BLOCK] ^ stg_r[BLOCK+1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= {WIDTH{1'b0}};
                b_q[k] <= {WIDTH{1'b0}};
                s_q[k] <= {WIDTH{1'b0}};
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= nxt_v[k];
                c_q[k] <= nxt_c[k];
                a_q[k] <= nxt_a[k];
                b_q[k] <= nxt_b[k];
                s_q[k] <= nxt_s[k];
            end
            ovf_q <= nxt_ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (32/8) plus a scoreboarded random run on a 16/4 instance.
module tb_pipelined_cla_adder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        in_valid, sub, out_ready;
    logic [31:0] a, b;
    logic        in_ready, out_valid, cout, overflow, zero;
    logic [31:0] sum;

    logic        x_in_valid, x_sub, x_out_ready;
    logic [15:0] x_a, x_b;
    logic        x_in_ready, x_out_valid, x_cout, x_overflow, x_zero;
    logic [15:0] x_sum;

    int errors = 0;
    int checks = 0;

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clock(clock), .reset(reset), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .a(x_a), .b(x_b), .sub(x_sub), .out_valid(x_out_valid), .out_ready(x_out_ready),
        .sum(x_sum), .cout(x_cout), .overflow(x_overflow), .zero(x_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a clock edge; checks exact latency and all result fields.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic [31:0] es, input logic ec,
                          input logic eo, input logic ez);
        in_valid = 1'b1; a = av; b = bv; sub = sv;
        #1 chk({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk({tag, "_early"}, out_valid, 1'b0);
        @(posedge clock); #1;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_flags"}, {cout, overflow, zero}, {ec, eo, ez});
    endtask

    logic [31:0] bp_sum [14];
    logic        bp_vld [14];
    logic [18:0] sb [$];
    logic [18:0] exp_r;
    logic [16:0] full;
    logic [15:0] beff;
    logic        acc_pending;
    int          nx, accepted, drained;

    initial begin
        reset = 1'b1; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        x_in_valid = 1'b0; x_sub = 1'b0; x_out_ready = 1'b1; x_a = '0; x_b = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_flags", {cout, overflow, zero}, 3'b001);
        chk("rst_in_ready", in_ready, 1'b1);

        run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_eq",  32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        @(posedge clock); #1;

        // Backpressure: 6 ops, out_ready low for 3 cycles from the 2nd result.
        for (int n = 0; n < 14; n++) begin bp_vld[n] = 1'b0; bp_sum[n] = '0; end
        bp_vld[4] = 1'b1; bp_sum[4] = 32'h101;
        for (int n = 5; n <= 8; n++) begin bp_vld[n] = 1'b1; bp_sum[n] = 32'h202; end
        for (int n = 9; n <= 12; n++) begin bp_vld[n] = 1'b1; bp_sum[n] = 32'h101 * (n - 6); end
        nx = 1; sub = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; a = 32'd1; b = 32'h100;
        #1 acc_pending = in_valid && in_ready;
        for (int n = 1; n <= 13; n++) begin
            @(posedge clock); #1;
            if (acc_pending) nx++;
            chk($sformatf("bp_vld_%0d", n), out_valid, bp_vld[n]);
            if (bp_vld[n]) chk($sformatf("bp_sum_%0d", n), sum, bp_sum[n]);
            out_ready = !(n >= 5 && n <= 7);
            in_valid = (nx <= 6);
            a = nx; b = nx << 8;
            #1;
            if (n >= 5 && n <= 7) chk($sformatf("bp_in_ready_%0d", n), in_ready, 1'b0);
            acc_pending = in_valid && in_ready;
        end
        chk("bp_accepts", nx, 7);
        in_valid = 1'b0; out_ready = 1'b1;

        // Reset with three operations in flight; the op offered during reset is dropped.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'd10 + i; b = 32'd1; sub = 1'b0;
            @(posedge clock); #1;
        end
        reset = 1'b1; a = 32'd9; b = 32'd9;
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0;
        chk("rstmid_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk($sformatf("rstmid_quiet_%0d", i), out_valid, 1'b0);
        end
        run_op("post_rst", 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;

        // 16/4 instance: exact latency, then random traffic against a reference model.
        x_in_valid = 1'b1; x_a = 16'h7FFF; x_b = 16'h0001; x_sub = 1'b0;
        @(posedge clock); #1;
        x_in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk("w16_early", x_out_valid, 1'b0);
        @(posedge clock); #1;
        chk("w16_latency", {x_out_valid, x_sum, x_cout, x_overflow, x_zero},
            {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0});
        @(posedge clock); #1;

        accepted = 0; drained = 0;
        for (int cyc = 0; cyc < 8000 && drained < 1000; cyc++) begin
            x_out_ready = ($urandom_range(0, 3) != 0);
            x_in_valid  = (accepted < 1000) && ($urandom_range(0, 1) == 1);
            x_a   = 16'($urandom);
            x_b   = 16'($urandom);
            x_sub = 1'($urandom_range(0, 1));
            #1;
            if (x_out_valid && x_out_ready) begin
                if (sb.size() == 0) chk("rand_spurious", x_out_valid, 1'b0);
                else begin
                    exp_r = sb.pop_front();
                    chk("rand_result", {x_sum, x_cout, x_overflow, x_zero}, exp_r);
                end
                drained++;
            end
            if (x_in_valid && x_in_ready) begin
                beff = x_sub ? ~x_b : x_b;
                full = {1'b0, x_a} + {1'b0, beff} + {16'h0, x_sub};
                exp_r = {full[15:0], full[16],
                         (x_a[15] == beff[15]) && (full[15] != x_a[15]),
                         full[15:0] == 16'h0};
                sb.push_back(exp_r);
                accepted++;
            end
            @(posedge clock); #1;
        end
        chk("rand_drained", drained, 1000);
        chk("rand_accepted", accepted, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
